signed_seq_div: RTL
===================

# signed_seq_div

Sequential signed integer divider for the pipelined MIPS datapath; the inverse operation of the combinational signed multiplier used by `mult`. Accepts a WL-bit signed dividend and divisor on a one-cycle `start` pulse, runs a radix-2 restoring divide on magnitudes over WL cycles, and applies the sign correction. It then presents quotient and remainder with a one-cycle `done` pulse. The pipeline stalls on `busy` while a `div` instruction is in flight, and the results feed the LO and HI registers.

## Interface
- `WL`, 15, operand/result word length in bits (≥ 2)
- `clk` in 1 — single clock, all state updates on rising edge
- `rst` in 1 — reset, synchronous, active-high
- `start` in 1 — request; sampled only in IDLE
- `dividend` in WL — signed numerator, sampled with `start`
- `divisor` in WL — signed denominator, sampled with `start`
- `quotient` out WL — signed quotient, truncated toward zero (→ LO)
- `remainder` out WL — signed remainder, sign of dividend (→ HI)
- `busy` out 1 — high from the cycle after accepted `start` until `done`
- `done` out 1 — one-cycle pulse, results valid
- `div_by_zero` out 1 — valid with `done`, high when divisor was 0

## Operation
- States:
  - IDLE: `start`=1 → CALC. Latches |dividend|, |divisor|, both sign bits, and the zero-divisor flag; clears the partial remainder; loads the counter to WL-1.
  - CALC: one restoring step per cycle, MSB first.
    - Shift {rem, quo} left one position.
    - Trial = rem − |divisor| at WL+1 bits.
    - Trial non-negative → rem ← trial, quo LSB ← 1; else quo LSB ← 0.
    - Counter 0 → FIX, else decrement.
  - FIX: write outputs, then → DONE.
    - Quotient: negated when the operand signs differ.
    - Remainder: negated when the dividend was negative.
  - DONE: `done`=1 for one cycle → IDLE.
- Magnitudes are held at WL bits unsigned, so |−2^(WL-1)| = 2^(WL-1) is representable.
- Overflow: −2^(WL-1) / −1 → quotient = −2^(WL-1) (wraps), remainder 0. This falls out of the algorithm; no special case.
- Divide by zero:
  - `div_by_zero`=1; quotient = all ones (−1); remainder = dividend.
  - Latency is identical to a normal divide; the CALC result is discarded in FIX.
- `start` while not IDLE is ignored; it is not queued.
- Outputs hold their last values from FIX until the next FIX or reset. IDLE does not clear them.
- Operands are captured at `start` and may change afterwards without effect.

## Timing
- Reset, taking effect at the next edge from any state (abort mid-CALC allowed, no `done` for the aborted op):
  - state = IDLE
  - `quotient`, `remainder` = 0
  - `busy`, `done`, `div_by_zero` = 0
- Cycle numbering: `start` sampled high in IDLE at edge 0.
  - Edges 1..WL: CALC.
  - Edge WL+1: FIX.
  - `done`=1 during the cycle after edge WL+1, i.e. latency WL+2 cycles; 17 for WL=15.
- `busy`:
  - Registered high from edge 0 through the end of the `done` cycle.
  - `busy` and `done` overlap in the final cycle.
  - Low in IDLE.
- Back-to-back: the earliest accepted next `start` is in the IDLE cycle after `done`. Initiation interval is WL+3.
- `start` and `rst` in the same cycle: reset wins.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, CALC, FIX, DONE}, 2-bit encoding
  - default `WL` constant
  - `CNT_W` = $clog2(WL)
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Kept separate so a future unrolled or pipelined divider can reuse it.
- FSM, counter, sign/zero latch and FIX logic live in the top module.

## Test plan
- WL=15 throughout; a full-range sweep against $signed `/` and `%` must also be run as part of these directed checks.
- 100 / 7 → q=14, r=2, `div_by_zero`=0, `done` exactly 17 cycles after `start`.
- Sign matrix:
  - −100 / 7 → q=−14, r=−2
  - 100 / −7 → q=−14, r=2
  - −100 / −7 → q=14, r=−2
- Boundary:
  - −16384 / −1 → q=−16384, r=0
  - −16384 / 1 → q=−16384, r=0
  - 3 / 5 → q=0, r=3
- 5 / 0 → q=0x7FFF (−1), r=5, `div_by_zero`=1, same 17-cycle latency.
- Start 100/7, pulse `start` with 9/3 at cycle 5 → second request ignored, result 14/2. A `start` in the cycle after `done` → 3/0 after 17 more cycles.
- Assert `rst` during CALC cycle 8 → next cycle state IDLE, all outputs 0, no `done`. A subsequent 100/7 completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding and
// default sizing constants.
package div_pkg;

  localparam int DEF_WL = 15;
  localparam int CNT_W  = $clog2(DEF_WL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration on unsigned magnitudes.
// Standalone so an unrolled or pipelined divider can chain copies of it.
module div_step #(
  parameter int WL = 15
) (
  input  logic [WL-1:0] i_rem,
  input  logic [WL-1:0] i_quo,
  input  logic [WL-1:0] i_dvs,
  output logic [WL-1:0] o_rem,
  output logic [WL-1:0] o_quo
);

  logic [WL:0] w_shift;
  logic [WL:0] w_trial;

  // The shifted remainder is always below 2^WL, so at WL+1 bits the
  // trial MSB is a reliable "went negative" flag.
  assign w_shift = {i_rem, i_quo[WL-1]};
  assign w_trial = w_shift - {1'b0, i_dvs};

  assign o_rem = w_trial[WL] ? w_shift[WL-1:0] : w_trial[WL-1:0];
  assign o_quo = {i_quo[WL-2:0], ~w_trial[WL]};

endmodule

// File: rtl/signed_seq_div.sv
// Sequential signed divider: WL restoring steps on magnitudes, then sign
// correction; results feed LO (quotient) and HI (remainder).
module signed_seq_div
  import div_pkg::*;
#(
  parameter int WL = DEF_WL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WL-1:0] dividend,
  input  logic [WL-1:0] divisor,
  output logic [WL-1:0] quotient,
  output logic [WL-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = $clog2(WL);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WL-1:0] r_rem;
  logic [WL-1:0] r_quo;
  logic [WL-1:0] r_dvs;
  logic [WL-1:0] r_dend_mag;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dz;
  logic [WL-1:0] r_quotient;
  logic [WL-1:0] r_remainder;
  logic          r_busy;
  logic          r_done;
  logic          r_div_by_zero;

  logic [WL-1:0] w_dend_mag;
  logic [WL-1:0] w_dvs_mag;
  logic [WL-1:0] w_rem_next;
  logic [WL-1:0] w_quo_next;
  logic [WL-1:0] w_rem_signed;

  // Unsigned WL-bit magnitudes: -2^(WL-1) maps onto 2^(WL-1) unchanged.
  assign w_dend_mag = dividend[WL-1] ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag  = divisor[WL-1]  ? (~divisor + 1'b1)  : divisor;

  assign w_rem_signed = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  div_step #(.WL(WL)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_next),
    .o_quo (w_quo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_dend_mag    <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= CALC;
            r_busy     <= 1'b1;
            r_rem      <= '0;
            r_quo      <= w_dend_mag;
            r_dvs      <= w_dvs_mag;
            r_dend_mag <= w_dend_mag;
            r_neg_q    <= dividend[WL-1] ^ divisor[WL-1];
            r_neg_r    <= dividend[WL-1];
            r_dz       <= (divisor == '0);
            r_cnt      <= CW'(WL - 1);
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          // A zero divisor keeps the full latency; the CALC result is dropped.
          if (r_dz) begin
            r_quotient  <= '1;
            r_remainder <= r_neg_r ? (~r_dend_mag + 1'b1) : r_dend_mag;
          end else begin
            r_quotient  <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
            r_remainder <= w_rem_signed;
          end
          r_div_by_zero <= r_dz;
          r_done        <= 1'b1;
          r_state       <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

endmodule
